// File: rtl/multu_hilo_unit.sv
// -----------------------------------------------------------------------------
// multu_hilo_unit
//
// Sequential shift-and-add unsigned multiplier that writes its 2*WIDTH-bit
// product into a Hi/Lo register pair. The Hi/Lo pair can be read
// combinationally through a select, and the unit raises a pipeline interlock
// (stall) when a Hi/Lo read is attempted while a multiply is in flight.
//
// Ports
//   clk            in   clock; all state changes on the rising edge
//   rst_n          in   asynchronous active-low reset
//   SignaltoMULTU  in   start request; accepted only in IDLE
//   SignaltoMUX    in   [1:0] read select: 01 = Hi, 10 = Lo, else none
//   srcA           in   [WIDTH-1:0] multiplicand, sampled on the accepting edge
//   srcB           in   [WIDTH-1:0] multiplier, sampled on the accepting edge
//   hiloOut        out  [WIDTH-1:0] selected Hi or Lo value (zero if none)
//   busy           out  high in RUN and DONE
//   done           out  one-cycle completion pulse (DONE state)
//   stall          out  busy while a Hi/Lo read is selected
//
// Configuration
//   MULTU_EARLY_TERM_EN  when defined, RUN ends as soon as the remaining
//                        multiplier bits are all zero; the accumulator is then
//                        realigned so the product is unchanged.
// -----------------------------------------------------------------------------
module multu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SignaltoMULTU,
  input  logic [1:0]       SignaltoMUX,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] hiloOut,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  logic [WIDTH-1:0]     b_reg, b_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [WIDTH-1:0]     hi_reg, hi_next;
  logic [WIDTH-1:0]     lo_reg, lo_next;

  // One iteration of the shift-and-add datapath
  logic [WIDTH:0]       sum_step;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     b_step;
  logic [CW-1:0]        cnt_step;
  logic [2*WIDTH-1:0]   aligned;
  logic                 finish;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
      cnt_reg <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
    end else begin
      a_reg   <= a_next;
      b_reg   <= b_next;
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;

    // Add the multiplicand into the upper half (keeping the carry), then
    // shift the whole accumulator right by one; the carry lands in the MSB.
    sum_step = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (b_reg[0] ? {1'b0, a_reg} : '0);
    acc_step = {sum_step, acc_reg[WIDTH-1:1]};
    b_step   = b_reg >> 1;
    cnt_step = cnt_reg - 1'b1;

`ifdef MULTU_EARLY_TERM_EN
    finish  = (cnt_step == '0) || (b_step == '0);
    // Skipped iterations would only have shifted right, so do them at once.
    aligned = acc_step >> cnt_step;
`else
    finish  = (cnt_step == '0);
    aligned = acc_step;
`endif

    unique case (state_reg)
      IDLE: begin
        if (SignaltoMULTU) begin
          a_next     = srcA;
          b_next     = srcB;
          acc_next   = '0;
          cnt_next   = CW'(WIDTH);
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next = acc_step;
        b_next   = b_step;
        cnt_next = cnt_step;
        if (finish) begin
          hi_next    = aligned[2*WIDTH-1:WIDTH];
          lo_next    = aligned[WIDTH-1:0];
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs
  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == DONE);
  assign stall = busy && ((SignaltoMUX == 2'b01) || (SignaltoMUX == 2'b10));

  always_comb begin
    hiloOut = '0;
    case (SignaltoMUX)
      2'b01:   hiloOut = hi_reg;
      2'b10:   hiloOut = lo_reg;
      default: hiloOut = '0;
    endcase
  end

endmodule
